// File: rtl/noc_pkg.sv
// Shared definitions for the NoC packet sink.
// Holds the header field layout, the error-flag bit positions inside
// err_flags, the receive FSM state type and a helper that assembles an
// error vector from individual error conditions.
package noc_pkg;

    localparam int unsigned FIELD_W    = 4;

    localparam int unsigned DEST_X_LSB = 0;
    localparam int unsigned DEST_Y_LSB = 4;
    localparam int unsigned SRC_X_LSB  = 8;
    localparam int unsigned SRC_Y_LSB  = 12;
    localparam int unsigned LEN_LSB    = 16;
    localparam int unsigned SEQ_LSB    = 24;

    // err_flags = {proto, seq, len, dest}
    localparam int unsigned ERR_DEST   = 0;
    localparam int unsigned ERR_LEN    = 1;
    localparam int unsigned ERR_SEQ    = 2;
    localparam int unsigned ERR_PROTO  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } sink_state_t;

    function automatic logic [3:0] err_vec(input logic proto, input logic seq,
                                           input logic len, input logic dest);
        logic [3:0] v;
        v            = '0;
        v[ERR_PROTO] = proto;
        v[ERR_SEQ]   = seq;
        v[ERR_LEN]   = len;
        v[ERR_DEST]  = dest;
        return v;
    endfunction

endpackage

// File: rtl/noc_hdr_decode.sv
// Combinational header decoder.
// Splits a header flit into source, length and sequence fields and compares
// the destination against this node and the sequence against the expected one.
//   hdr          : low 32 bits of the header flit
//   expected_seq : sequence number the sink expects next
//   src          : {src_y, src_x}
//   len          : number of body flits, tail included
//   seq          : packet sequence number
//   dest_match   : destination equals {Y_ID, X_ID}
//   seq_match    : seq equals expected_seq
module noc_hdr_decode
    import noc_pkg::*;
#(
    parameter int unsigned X_ID = 0,
    parameter int unsigned Y_ID = 0
) (
    input  logic [31:0] hdr,
    input  logic [7:0]  expected_seq,
    output logic [7:0]  src,
    output logic [7:0]  len,
    output logic [7:0]  seq,
    output logic        dest_match,
    output logic        seq_match
);

    localparam logic [FIELD_W-1:0] MY_X = FIELD_W'(X_ID);
    localparam logic [FIELD_W-1:0] MY_Y = FIELD_W'(Y_ID);

    always_comb begin
        src        = {hdr[SRC_Y_LSB +: FIELD_W], hdr[SRC_X_LSB +: FIELD_W]};
        len        = hdr[LEN_LSB +: 8];
        seq        = hdr[SEQ_LSB +: 8];
        dest_match = (hdr[DEST_X_LSB +: FIELD_W] == MY_X) &&
                     (hdr[DEST_Y_LSB +: FIELD_W] == MY_Y);
        seq_match  = (hdr[SEQ_LSB +: 8] == expected_seq);
    end

endmodule

// File: rtl/noc_packet_sink.sv
// Terminal NoC receive endpoint.
// Accepts the flit stream of a router local port, reassembles packets,
// checks destination, sequence, length/payload and framing, and keeps
// good/bad packet counters plus sticky error flags. Never transmits.
//   noc_clk, noc_rst_n  : clock, asynchronous active-low reset
//   receive_*           : flit handshake from the router (ready is ours)
//   stall               : forces receive_ready low
//   pkt_done/ok/src     : one-cycle completion report of the last packet
//   receive_num/err_num : wrapping good/bad packet counters
//   err_flags           : sticky {proto, seq, len, dest}
module noc_packet_sink
    import noc_pkg::*;
#(
    parameter int unsigned NOC_DATA_WIDTH = 32,
    parameter int unsigned X_ID           = 0,
    parameter int unsigned Y_ID           = 0
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst_n,
    input  logic                      receive_valid,
    output logic                      receive_ready,
    input  logic [NOC_DATA_WIDTH-1:0] receive_flit,
    input  logic                      receive_is_header,
    input  logic                      receive_is_tail,
    input  logic                      stall,
    output logic                      pkt_done,
    output logic                      pkt_ok,
    output logic [7:0]                pkt_src,
    output logic [7:0]                receive_num,
    output logic [7:0]                err_num,
    output logic [3:0]                err_flags
);

    sink_state_t state, state_nxt;

    logic       rst_done;
    logic [7:0] expected_seq;
    logic [7:0] cur_seq, cur_len, cur_src, body_cnt;
    logic       cur_dest_bad, cur_seq_bad, cur_len_bad;

    logic [7:0] h_src, h_len, h_seq;
    logic       h_dest_match, h_seq_match;

    logic       accept, pl_ok;
    logic [7:0] cnt_inc;

    logic       done_nxt, ok_nxt, good_add, load_hdr, body_step;
    logic [1:0] bad_add;
    logic [7:0] src_nxt;
    logic [3:0] flags_nxt, pkt_err, hdr_err;

    noc_hdr_decode #(
        .X_ID (X_ID),
        .Y_ID (Y_ID)
    ) u_hdr_decode (
        .hdr          (receive_flit[31:0]),
        .expected_seq (expected_seq),
        .src          (h_src),
        .len          (h_len),
        .seq          (h_seq),
        .dest_match   (h_dest_match),
        .seq_match    (h_seq_match)
    );

    // rst_done keeps ready low while reset is held, then follows ~stall.
    assign receive_ready = rst_done & ~stall;
    assign accept        = receive_valid & receive_ready;
    assign cnt_inc       = (body_cnt == 8'hFF) ? body_cnt : body_cnt + 8'd1;
    assign pl_ok         = (receive_flit[15:0] == {cur_seq, cnt_inc});

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // A header arriving in BODY first closes the aborted packet, then falls
    // through to the common header handling below, so a new packet starts in
    // the same cycle. The later assignments report the newer packet.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        ok_nxt    = pkt_ok;
        src_nxt   = pkt_src;
        flags_nxt = err_flags;
        good_add  = 1'b0;
        bad_add   = 2'd0;
        load_hdr  = 1'b0;
        body_step = 1'b0;
        pkt_err   = '0;
        hdr_err   = '0;
        if (accept) begin
            unique case (state)
                IDLE: begin
                    if (!receive_is_header) begin
                        flags_nxt[ERR_PROTO] = 1'b1;
                        bad_add              = 2'd1;
                    end
                end
                BODY: begin
                    if (receive_is_header) begin
                        pkt_err   = err_vec(1'b1, cur_seq_bad, cur_len_bad, cur_dest_bad);
                        done_nxt  = 1'b1;
                        ok_nxt    = 1'b0;
                        src_nxt   = cur_src;
                        flags_nxt = flags_nxt | pkt_err;
                        bad_add   = 2'd1;
                        state_nxt = IDLE;
                    end else begin
                        body_step = 1'b1;
                        if (receive_is_tail) begin
                            pkt_err   = err_vec(1'b0, cur_seq_bad,
                                                cur_len_bad | ~pl_ok | (cnt_inc != cur_len),
                                                cur_dest_bad);
                            done_nxt  = 1'b1;
                            ok_nxt    = (pkt_err == '0);
                            src_nxt   = cur_src;
                            flags_nxt = flags_nxt | pkt_err;
                            if (pkt_err == '0) good_add = 1'b1;
                            else               bad_add  = 2'd1;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: ;
            endcase
            if (receive_is_header) begin
                load_hdr = 1'b1;
                if (receive_is_tail) begin
                    hdr_err   = err_vec(1'b0, ~h_seq_match, (h_len != 8'd0), ~h_dest_match);
                    done_nxt  = 1'b1;
                    ok_nxt    = (hdr_err == '0);
                    src_nxt   = h_src;
                    flags_nxt = flags_nxt | hdr_err;
                    if (hdr_err == '0) good_add = 1'b1;
                    else               bad_add  = bad_add + 2'd1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = BODY;
                end
            end
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            rst_done     <= 1'b0;
            pkt_done     <= 1'b0;
            pkt_ok       <= 1'b0;
            pkt_src      <= '0;
            receive_num  <= '0;
            err_num      <= '0;
            err_flags    <= '0;
            expected_seq <= '0;
            cur_seq      <= '0;
            cur_len      <= '0;
            cur_src      <= '0;
            body_cnt     <= '0;
            cur_dest_bad <= 1'b0;
            cur_seq_bad  <= 1'b0;
            cur_len_bad  <= 1'b0;
        end else begin
            rst_done    <= 1'b1;
            pkt_done    <= done_nxt;
            pkt_ok      <= ok_nxt;
            pkt_src     <= src_nxt;
            err_flags   <= flags_nxt;
            receive_num <= receive_num + {7'd0, good_add};
            err_num     <= err_num + {6'd0, bad_add};
            if (load_hdr) begin
                expected_seq <= h_seq + 8'd1;
                cur_seq      <= h_seq;
                cur_len      <= h_len;
                cur_src      <= h_src;
                cur_dest_bad <= ~h_dest_match;
                cur_seq_bad  <= ~h_seq_match;
                cur_len_bad  <= 1'b0;
                body_cnt     <= '0;
            end else if (body_step) begin
                body_cnt    <= cnt_inc;
                cur_len_bad <= cur_len_bad | ~pl_ok;
            end
        end
    end

endmodule

// File: tb/tb_noc_packet_sink.sv
module tb_noc_packet_sink;

    localparam int unsigned W     = 32;
    localparam int unsigned XI    = 1;
    localparam int unsigned YI    = 1;
    localparam logic [7:0]  MY_ID = 8'((YI << 4) | XI);

    logic          noc_clk = 1'b0;
    logic          noc_rst_n = 1'b1;
    logic          receive_valid = 1'b0;
    logic          receive_ready;
    logic [W-1:0]  receive_flit = '0;
    logic          receive_is_header = 1'b0;
    logic          receive_is_tail = 1'b0;
    logic          stall = 1'b0;
    logic          pkt_done;
    logic          pkt_ok;
    logic [7:0]    pkt_src;
    logic [7:0]    receive_num;
    logic [7:0]    err_num;
    logic [3:0]    err_flags;

    noc_packet_sink #(
        .NOC_DATA_WIDTH (W),
        .X_ID           (XI),
        .Y_ID           (YI)
    ) dut (
        .noc_clk           (noc_clk),
        .noc_rst_n         (noc_rst_n),
        .receive_valid     (receive_valid),
        .receive_ready     (receive_ready),
        .receive_flit      (receive_flit),
        .receive_is_header (receive_is_header),
        .receive_is_tail   (receive_is_tail),
        .stall             (stall),
        .pkt_done          (pkt_done),
        .pkt_ok            (pkt_ok),
        .pkt_src           (pkt_src),
        .receive_num       (receive_num),
        .err_num           (err_num),
        .err_flags         (err_flags)
    );

    always #5 noc_clk = ~noc_clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Packet-level reference model: one expected completion per packet.
    typedef struct {
        logic       ok;
        logic [7:0] src;
        logic [7:0] rnum;
        logic [7:0] enm;
        logic [3:0] flags;
    } done_t;

    done_t       exp_q[$];
    int          m_rnum, m_enum;
    logic [3:0]  m_flags;
    logic [7:0]  m_seq;
    bit          pend;
    logic [7:0]  pend_src;
    logic [3:0]  pend_flags;
    int          n_done_seen, n_done_exp;
    int          stall_mode = 0;
    int unsigned cyc = 0;

    task automatic model_reset();
        m_rnum = 0; m_enum = 0; m_flags = '0; m_seq = '0;
        pend = 0; pend_src = '0; pend_flags = '0;
        exp_q.delete();
        n_done_seen = 0; n_done_exp = 0;
    endtask

    // e = {proto, seq, len, dest}
    task automatic model_complete(input logic [7:0] src, input logic [3:0] e);
        done_t d;
        if (e == 4'd0) m_rnum = (m_rnum + 1) % 256;
        else           m_enum = (m_enum + 1) % 256;
        m_flags = m_flags | e;
        d.ok = (e == 4'd0); d.src = src; d.rnum = 8'(m_rnum); d.enm = 8'(m_enum); d.flags = m_flags;
        exp_q.push_back(d);
        n_done_exp++;
    endtask

    task automatic idle(input int n);
        receive_valid = 1'b0;
        stall = 1'b0;
        repeat (n) @(posedge noc_clk);
        #1;
    endtask

    task automatic send_flit(input logic [W-1:0] f, input logic h, input logic t);
        int unsigned waited;
        waited = 0;
        receive_valid = 1'b1; receive_flit = f; receive_is_header = h; receive_is_tail = t;
        forever begin
            case (stall_mode)
                0:       stall = 1'b0;
                1:       stall = cyc[0];
                default: stall = ($urandom_range(0, 3) == 0);
            endcase
            @(posedge noc_clk);
            cyc++;
            if (receive_ready) break;
            waited++;
            if (waited > 100) begin
                chk("accept_timeout", {31'd0, receive_ready}, 32'd1);
                break;
            end
            #1;
        end
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] dst, input logic [7:0] src, input logic [7:0] seq,
                            input logic [7:0] len, input int nbody, input int bad_pl, input bit abort);
        logic dest_bad, seq_bad, pl_bad, len_bad;
        logic [W-1:0] f;
        logic [15:0] flip;
        if (pend) begin
            model_complete(pend_src, pend_flags | 4'b1000);
            pend = 0;
        end
        dest_bad = (dst != MY_ID);
        seq_bad  = (seq != m_seq);
        m_seq    = seq + 8'd1;
        pl_bad   = (bad_pl != 0);
        if (abort) begin
            pend = 1; pend_src = src; pend_flags = {1'b0, seq_bad, pl_bad, dest_bad};
        end else begin
            len_bad = pl_bad || (nbody != int'(len));
            model_complete(src, {1'b0, seq_bad, len_bad, dest_bad});
        end
        send_flit({seq, len, src, dst}, 1'b1, (nbody == 0) && !abort);
        for (int i = 1; i <= nbody; i++) begin
            f = W'($urandom);
            f[15:0] = {seq, i[7:0]};
            if (i == bad_pl) begin
                flip = 16'($urandom_range(1, 65535));
                f[15:0] = f[15:0] ^ flip;
            end
            send_flit(f, 1'b0, (i == nbody) && !abort);
        end
    endtask

    task automatic send_stray();
        logic [W-1:0] f;
        m_flags[3] = 1'b1;
        m_enum = (m_enum + 1) % 256;
        f = W'($urandom);
        send_flit(f, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic check_totals(input string ph);
        idle(4);
        chk({ph, "_receive_num"}, receive_num, m_rnum);
        chk({ph, "_err_num"}, err_num, m_enum);
        chk({ph, "_err_flags"}, err_flags, m_flags);
        chk({ph, "_done_count"}, n_done_seen, n_done_exp);
        chk({ph, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        receive_valid = 1'b0; stall = 1'b0;
        noc_rst_n = 1'b0;
        repeat (2) @(posedge noc_clk);
        #1;
        chk("reset_outputs", {3'd0, receive_ready, pkt_done, pkt_ok, pkt_src, receive_num, err_num, err_flags}, 32'd0);
        model_reset();
        noc_rst_n = 1'b1;
        @(posedge noc_clk);
        #1;
    endtask

    always @(negedge noc_clk) begin
        done_t d;
        if (noc_rst_n && pkt_done) begin
            n_done_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {31'd0, pkt_done}, 32'd0);
            end else begin
                d = exp_q.pop_front();
                chk("pkt_ok", {31'd0, pkt_ok}, {31'd0, d.ok});
                chk("pkt_src", pkt_src, d.src);
                chk("done_receive_num", receive_num, d.rnum);
                chk("done_err_num", err_num, d.enm);
                chk("done_err_flags", err_flags, d.flags);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] dst, seq, len;
        int nbody, bad_pl;
        bit abort;

        do_reset();

        // Directed cases
        stall_mode = 0;
        send_pkt(MY_ID, 8'h00, 8'd0,  8'd2, 2, 0, 0);  // good 2-flit body
        send_pkt(MY_ID, 8'h23, 8'd1,  8'd0, 0, 0, 0);  // single-flit good
        send_pkt(MY_ID, 8'h23, 8'd2,  8'd3, 0, 0, 0);  // single-flit, len 3
        send_pkt(8'h12, 8'h45, 8'd3,  8'd1, 1, 0, 0);  // dest_x = 2
        send_pkt(MY_ID, 8'h00, 8'd9,  8'd1, 1, 0, 0);  // seq gap
        send_pkt(MY_ID, 8'h00, 8'd10, 8'd1, 1, 0, 0);  // resync
        send_pkt(MY_ID, 8'h31, 8'd11, 8'd2, 2, 2, 0);  // corrupt tail payload
        send_stray();                                  // body flit in IDLE
        send_pkt(MY_ID, 8'h54, 8'd12, 8'd3, 1, 0, 1);  // aborted by next header
        send_pkt(MY_ID, 8'h54, 8'd13, 8'd1, 1, 0, 0);
        check_totals("directed");
        chk("directed_rnum_abs", receive_num, 32'd4);
        chk("directed_enum_abs", err_num, 32'd6);
        chk("directed_flags_abs", err_flags, 32'hF);

        // Randomized traffic with random stall
        stall_mode = 2;
        for (int p = 0; p < 200; p++) begin
            if (!pend && $urandom_range(0, 15) == 0) send_stray();
            dst    = ($urandom_range(0, 7) == 0) ? (MY_ID ^ 8'($urandom_range(1, 255))) : MY_ID;
            seq    = ($urandom_range(0, 7) == 0) ? (m_seq + 8'($urandom_range(1, 255))) : m_seq;
            len    = 8'($urandom_range(0, 4));
            nbody  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : int'(len);
            abort  = ($urandom_range(0, 9) == 0);
            if (pend && !abort && nbody == 0) nbody = 1;
            bad_pl = (nbody > 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, nbody)) : 0;
            send_pkt(dst, 8'($urandom), seq, len, nbody, bad_pl, abort);
        end
        if (pend) send_pkt(MY_ID, 8'h77, m_seq, 8'd1, 1, 0, 0);
        check_totals("random");

        // 300 good back-to-back packets, stall every other cycle
        do_reset();
        stall_mode = 1;
        for (int p = 0; p < 300; p++) begin
            len = 8'($urandom_range(0, 3));
            send_pkt(MY_ID, 8'($urandom), m_seq, len, int'(len), 0, 0);
        end
        check_totals("stream");
        chk("stream_rnum_abs", receive_num, 32'd44);
        chk("stream_enum_abs", err_num, 32'd0);

        // Reset in the middle of a packet
        stall_mode = 0;
        send_flit({8'd44, 8'd3, 8'h21, MY_ID}, 1'b1, 1'b0);
        send_flit({16'h0, 8'd44, 8'd1}, 1'b0, 1'b0);
        receive_valid = 1'b0;
        noc_rst_n = 1'b0;
        #1;
        chk("midpkt_reset_outputs", {3'd0, receive_ready, pkt_done, pkt_ok, pkt_src, receive_num, err_num, err_flags}, 32'd0);
        @(posedge noc_clk);
        #1;
        model_reset();
        noc_rst_n = 1'b1;
        @(posedge noc_clk);
        #1;
        send_pkt(MY_ID, 8'h42, 8'd0, 8'd2, 2, 0, 0);
        check_totals("after_reset");
        chk("after_reset_rnum_abs", receive_num, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
